// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : ALU operator encoding, RV32I opcode constants and the decoded
//               issue bundle shared by the decode stage and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_LTU  = 4'd14,
        ALU_GEU  = 4'd15
    } alu_op;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] c_F7_BASE  = 7'b0000000;
    localparam logic [6:0] c_F7_ALT   = 7'b0100000;

    typedef struct packed {
        alu_op       operator;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic        is_branch;
    } alu_bundle_t;

    // Shared funct3 mapping of OP and OP-IMM when funct7 selects the base form.
    function automatic alu_op base_op(input logic [2:0] funct3);
        alu_op op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
// ============================================================================
// Module      : alu_regfile
// Description : 31x32 integer register file, x0 hard-wired to zero, two
//               combinational read ports and one synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_raddr_a,
    output logic [31:0] o_rdata_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_b,
    input  logic        i_wen,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_mem [1:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wen && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_mem[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/alu_decode_stage.sv
// ============================================================================
// Module      : alu_decode_stage
// Description : RV32I issue stage: decodes OP/OP-IMM/BRANCH, reads operands,
//               tracks pending writebacks and registers the ALU bundle.
//               Define ALU_DECODE_FORWARD_EN to bypass same-cycle writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode_stage
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    output alu_op       alu_operator_o,
    output logic [31:0] alu_op_a_o,
    output logic [31:0] alu_op_b_o,
    output logic [4:0]  alu_rd_o,
    output logic        alu_is_branch_o,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        illegal_o
);

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_funct3 = instr_i[14:12];
    assign w_rs1    = instr_i[19:15];
    assign w_rs2    = instr_i[24:20];
    assign w_funct7 = instr_i[31:25];

    logic        w_legal;
    alu_op       w_op;
    logic        w_uses_rs2;
    logic        w_is_branch;
    logic        w_shamt_sel;

    always_comb begin
        w_legal     = 1'b0;
        w_op        = ALU_ADD;
        w_uses_rs2  = 1'b0;
        w_is_branch = 1'b0;
        w_shamt_sel = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_uses_rs2 = 1'b1;
                if (w_funct7 == c_F7_BASE) begin
                    w_legal = 1'b1;
                    w_op    = base_op(w_funct3);
                end else if ((w_funct7 == c_F7_ALT) && (w_funct3 == 3'b000)) begin
                    w_legal = 1'b1;
                    w_op    = ALU_SUB;
                end else if ((w_funct7 == c_F7_ALT) && (w_funct3 == 3'b101)) begin
                    w_legal = 1'b1;
                    w_op    = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                case (w_funct3)
                    3'b001: begin
                        w_shamt_sel = 1'b1;
                        w_legal     = (w_funct7 == c_F7_BASE);
                        w_op        = ALU_SLL;
                    end
                    3'b101: begin
                        w_shamt_sel = 1'b1;
                        w_legal     = (w_funct7 == c_F7_BASE) || (w_funct7 == c_F7_ALT);
                        w_op        = (w_funct7 == c_F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: begin
                        w_legal = 1'b1;
                        w_op    = base_op(w_funct3);
                    end
                endcase
            end
            OPC_BRANCH: begin
                w_uses_rs2  = 1'b1;
                w_is_branch = 1'b1;
                w_legal     = 1'b1;
                case (w_funct3)
                    3'b000:  w_op = ALU_EQ;
                    3'b001:  w_op = ALU_NE;
                    3'b100:  w_op = ALU_LT;
                    3'b101:  w_op = ALU_GE;
                    3'b110:  w_op = ALU_LTU;
                    3'b111:  w_op = ALU_GEU;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Branches carry immediate bits in the rd field; they never own a destination.
    logic [4:0]  w_rd_eff;
    assign w_rd_eff = w_is_branch ? 5'd0 : w_rd;

    logic [31:0] w_rf_a;
    logic [31:0] w_rf_b;

    alu_regfile u_regfile (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rf_a),
        .i_raddr_b (w_rs2),
        .o_rdata_b (w_rf_b),
        .i_wen     (wb_en_i),
        .i_waddr   (wb_addr_i),
        .i_wdata   (wb_data_i)
    );

    logic        w_wb_hit;
    logic [31:0] w_clr_mask;
    logic [31:0] w_busy_view;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] r_busy;

    assign w_wb_hit   = wb_en_i && (wb_addr_i != 5'd0);
    assign w_clr_mask = w_wb_hit ? (32'd1 << wb_addr_i) : 32'd0;

`ifdef ALU_DECODE_FORWARD_EN
    assign w_busy_view = r_busy & ~w_clr_mask;
    assign w_rs1_val   = (w_wb_hit && (wb_addr_i == w_rs1)) ? wb_data_i : w_rf_a;
    assign w_rs2_val   = (w_wb_hit && (wb_addr_i == w_rs2)) ? wb_data_i : w_rf_b;
`else
    assign w_busy_view = r_busy;
    assign w_rs1_val   = w_rf_a;
    assign w_rs2_val   = w_rf_b;
`endif

    logic        w_hazard;
    logic        w_accept;
    logic        w_issue;
    logic [31:0] w_set_mask;

    assign w_hazard = w_legal && (w_busy_view[w_rs1]
                                  || (w_uses_rs2 && w_busy_view[w_rs2])
                                  || w_busy_view[w_rd_eff]);

    assign instr_ready_o = !rst_i && !w_hazard && (!alu_valid_o || alu_ready_i);
    assign w_accept      = instr_valid_i && instr_ready_o;
    assign w_issue       = w_accept && w_legal;
    assign w_set_mask    = (w_issue && !w_is_branch) ? (32'd1 << w_rd_eff) : 32'd0;

    // Set is applied after clear so a same-cycle re-allocation keeps the bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
        end
    end

    alu_bundle_t w_bundle;
    alu_bundle_t r_bundle;
    logic        r_valid;
    logic        r_illegal;

    assign w_bundle = '{
        operator:  w_op,
        op_a:      w_rs1_val,
        op_b:      w_uses_rs2  ? w_rs2_val :
                   w_shamt_sel ? {27'd0, w_rs2} : sext12(instr_i[31:20]),
        rd:        w_rd_eff,
        is_branch: w_is_branch
    };

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bundle  <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_issue) begin
                r_bundle <= w_bundle;
                r_valid  <= 1'b1;
            end else if (alu_ready_i) begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign alu_valid_o     = r_valid;
    assign alu_operator_o  = r_bundle.operator;
    assign alu_op_a_o      = r_bundle.op_a;
    assign alu_op_b_o      = r_bundle.op_b;
    assign alu_rd_o        = r_bundle.rd;
    assign alu_is_branch_o = r_bundle.is_branch;
    assign illegal_o       = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
// ============================================================================
// Module      : tb_alu_decode_stage
// Description : Directed and randomized self-checking bench for alu_decode_stage
//               against a behavioural issue-stage model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_decode_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        instr_ready_o;
    logic        alu_valid_o;
    logic        alu_ready_i;
    alu_op       alu_operator_o;
    logic [31:0] alu_op_a_o;
    logic [31:0] alu_op_b_o;
    logic [4:0]  alu_rd_o;
    logic        alu_is_branch_o;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        illegal_o;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_valid_i   (instr_valid_i),
        .instr_i         (instr_i),
        .instr_ready_o   (instr_ready_o),
        .alu_valid_o     (alu_valid_o),
        .alu_ready_i     (alu_ready_i),
        .alu_operator_o  (alu_operator_o),
        .alu_op_a_o      (alu_op_a_o),
        .alu_op_b_o      (alu_op_b_o),
        .alu_rd_o        (alu_rd_o),
        .alu_is_branch_o (alu_is_branch_o),
        .wb_en_i         (wb_en_i),
        .wb_addr_i       (wb_addr_i),
        .wb_data_i       (wb_data_i),
        .illegal_o       (illegal_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers, pending-writeback set, output bundle.
    logic [31:0] m_rf   [32];
    bit          m_busy [32];
    bit          m_valid;
    bit          m_illegal;
    alu_op       m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_rd;
    bit          m_br;

    typedef struct {
        bit          legal;
        alu_op       op;
        bit          use2;
        bit          br;
        logic [31:0] b_imm;
    } dec_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] ins);
        alu_op base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        alu_op brt  [8] = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
        bit    brok [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        dec_t        d;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        d.legal = 1'b0; d.op = ALU_ADD; d.use2 = 1'b0; d.br = 1'b0; d.b_imm = 32'd0;
        if (opc == 7'h33) begin
            d.use2 = 1'b1;
            if (f7 == 7'h00) begin d.legal = 1'b1; d.op = base[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin d.legal = 1'b1; d.op = ALU_SUB; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin d.legal = 1'b1; d.op = ALU_SRA; end
        end else if (opc == 7'h13) begin
            d.legal = 1'b1;
            d.op    = base[f3];
            d.b_imm = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) begin
                d.b_imm = {27'd0, ins[24:20]};
                d.legal = (f7 == 7'h00);
            end
            if (f3 == 3'd5) begin
                d.b_imm = {27'd0, ins[24:20]};
                d.legal = (f7 == 7'h00) || (f7 == 7'h20);
                if (f7 == 7'h20) d.op = ALU_SRA;
            end
        end else if (opc == 7'h63) begin
            d.use2  = 1'b1;
            d.br    = 1'b1;
            d.legal = brok[f3];
            d.op    = brt[f3];
        end
        return d;
    endfunction

    function automatic bit busy_now(input logic [4:0] r, input bit we, input logic [4:0] wa);
`ifdef ALU_DECODE_FORWARD_EN
        if (we && wa == r) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    // One clock: drive at negedge, check ready, advance the model, check outputs.
    task automatic cycle(input bit r, input bit iv, input logic [31:0] ins, input bit ar,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd, output bit acc);
        dec_t        d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        bit          haz;
        bit          rdy;
        @(negedge clk);
        rst = r; instr_valid_i = iv; instr_i = ins; alu_ready_i = ar;
        wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
        #1;
        d   = ref_decode(ins);
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        rd  = d.br ? 5'd0 : ins[11:7];
        a   = m_rf[rs1];
        b   = d.use2 ? m_rf[rs2] : d.b_imm;
`ifdef ALU_DECODE_FORWARD_EN
        if (we && wa != 5'd0) begin
            if (rs1 == wa) a = wd;
            if (d.use2 && rs2 == wa) b = wd;
        end
`endif
        haz = busy_now(rs1, we, wa) || (d.use2 && busy_now(rs2, we, wa)) || busy_now(rd, we, wa);
        rdy = !r && !(d.legal && haz) && (!m_valid || ar);
        chk("instr_ready", instr_ready_o, rdy);
        acc = iv && rdy;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin m_rf[i] = 32'd0; m_busy[i] = 1'b0; end
            m_valid = 0; m_illegal = 0; m_op = ALU_ADD; m_a = 0; m_b = 0; m_rd = 0; m_br = 0;
        end else begin
            if (we && wa != 5'd0) begin m_rf[wa] = wd; m_busy[wa] = 1'b0; end
            if (acc && d.legal && !d.br && rd != 5'd0) m_busy[rd] = 1'b1;
            if (acc && d.legal) begin
                m_valid = 1; m_op = d.op; m_a = a; m_b = b; m_rd = rd; m_br = d.br;
            end else if (ar) begin
                m_valid = 0;
            end
            m_illegal = acc && !d.legal;
        end
        #1;
        chk("alu_valid", alu_valid_o, m_valid);
        chk("illegal", illegal_o, m_illegal);
        if (m_valid || r) begin
            chk("operator", 32'(alu_operator_o), 32'(m_op));
            chk("op_a", alu_op_a_o, m_a);
            chk("op_b", alu_op_b_o, m_b);
            chk("rd", alu_rd_o, m_rd);
            chk("is_branch", alu_is_branch_o, m_br);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [2:0] f3  = 3'($urandom);
        logic [6:0] f7  = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        int         k   = $urandom_range(0, 9);
        if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
        if (k < 4) return {f7, rs2, rs1, f3, rd, 7'h33};
        if (k < 7) begin
            if (f3 == 3'd1 || f3 == 3'd5) return {f7, rs2, rs1, f3, rd, 7'h13};
            return {12'($urandom), rs1, f3, rd, 7'h13};
        end
        if (k < 9) return {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'h63};
        return $urandom;
    endfunction

    localparam logic [31:0] c_ADDI_X1 = 32'h0050_0093;
    localparam logic [31:0] c_ADD_X2  = 32'h0010_8133;
    localparam logic [31:0] c_SRAI_X3 = 32'h4040_D193;
    localparam logic [31:0] c_BEQ     = 32'h0020_8063;
    localparam logic [31:0] c_JAL     = 32'h0000_006F;
    localparam logic [31:0] c_ADDI_X4 = 32'h0070_0213;
    localparam logic [31:0] c_ADDI_X5 = 32'h0090_0293;

    initial begin
        bit          acc;
        bit          have;
        bit          iv;
        bit          ar;
        bit          we;
        bit          r;
        logic [4:0]  wa;
        logic [31:0] cur;
        int          q[$];

        rst = 1'b1; instr_valid_i = 1'b0; instr_i = '0; alu_ready_i = 1'b0;
        wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        for (int i = 0; i < 32; i++) begin m_rf[i] = 32'd0; m_busy[i] = 1'b0; end
        m_valid = 0; m_illegal = 0; m_op = ALU_ADD; m_a = 0; m_b = 0; m_rd = 0; m_br = 0;

        cycle(1, 1, c_ADDI_X1, 1, 0, 5'd0, 32'd0, acc);
        cycle(1, 1, c_ADDI_X1, 1, 0, 5'd0, 32'd0, acc);
        chk("rst_operator_add", 32'(alu_operator_o), 32'd0);
        chk("rst_valid", alu_valid_o, 1'b0);

        cycle(0, 1, c_ADDI_X1, 1, 0, 5'd0, 32'd0, acc);
        chk("addi_valid", alu_valid_o, 1'b1);
        chk("addi_op", 32'(alu_operator_o), 32'(ALU_ADD));
        chk("addi_b", alu_op_b_o, 32'd5);
        chk("addi_rd", alu_rd_o, 32'd1);

        cycle(0, 1, c_ADD_X2, 1, 0, 5'd0, 32'd0, acc);
        chk("raw_stall", instr_ready_o, 1'b0);
        cycle(0, 1, c_ADD_X2, 1, 0, 5'd0, 32'd0, acc);
        cycle(0, 1, c_ADD_X2, 1, 1, 5'd1, 32'd5, acc);
`ifndef ALU_DECODE_FORWARD_EN
        chk("wb_bubble", alu_valid_o, 1'b0);
        cycle(0, 1, c_ADD_X2, 1, 0, 5'd0, 32'd0, acc);
`endif
        chk("add_valid", alu_valid_o, 1'b1);
        chk("add_op_not_sub", 32'(alu_operator_o), 32'(ALU_ADD));
        chk("add_a", alu_op_a_o, 32'd5);
        chk("add_b", alu_op_b_o, 32'd5);
        chk("add_rd", alu_rd_o, 32'd2);

        cycle(0, 0, 32'd0, 1, 1, 5'd2, 32'd10, acc);
        cycle(0, 1, c_SRAI_X3, 1, 0, 5'd0, 32'd0, acc);
        chk("srai_op", 32'(alu_operator_o), 32'(ALU_SRA));
        chk("srai_a", alu_op_a_o, 32'd5);
        chk("srai_b", alu_op_b_o, 32'd4);
        chk("srai_rd", alu_rd_o, 32'd3);

        cycle(0, 1, c_BEQ, 1, 1, 5'd3, 32'd7, acc);
        chk("beq_op", 32'(alu_operator_o), 32'(ALU_EQ));
        chk("beq_rd", alu_rd_o, 32'd0);
        chk("beq_branch", alu_is_branch_o, 1'b1);
        chk("beq_b", alu_op_b_o, 32'd10);

        cycle(0, 1, c_JAL, 1, 0, 5'd0, 32'd0, acc);
        chk("jal_illegal", illegal_o, 1'b1);
        chk("jal_no_bundle", alu_valid_o, 1'b0);
        cycle(0, 0, 32'd0, 1, 0, 5'd0, 32'd0, acc);
        chk("jal_pulse_end", illegal_o, 1'b0);

        cycle(0, 1, c_ADDI_X4, 0, 0, 5'd0, 32'd0, acc);
        cycle(0, 1, c_ADDI_X5, 0, 0, 5'd0, 32'd0, acc);
        chk("bp_ready", instr_ready_o, 1'b0);
        chk("bp_hold_rd", alu_rd_o, 32'd4);
        chk("bp_hold_b", alu_op_b_o, 32'd7);
        cycle(0, 1, c_ADDI_X5, 1, 0, 5'd0, 32'd0, acc);
        chk("bp_release_valid", alu_valid_o, 1'b1);
        chk("bp_release_rd", alu_rd_o, 32'd5);

        have = 1'b0;
        cur  = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            if (!have) begin cur = gen_instr(); have = 1'b1; end
            iv = ($urandom_range(0, 4) != 0);
            ar = ($urandom_range(0, 3) != 0);
            r  = (n == 1500);
            we = 1'b0;
            wa = 5'd0;
            q.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                we = 1'b1;
                wa = 5'(q[$urandom_range(0, q.size() - 1)]);
            end else if ($urandom_range(0, 15) == 0) begin
                we = 1'b1;
                wa = 5'($urandom_range(0, 7));
            end
            cycle(r, iv, cur, ar, we, wa, $urandom, acc);
            if (acc) have = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_decode_stage.md
# alu_decode_stage

- Issue stage directly upstream of `alu`.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes OP, OP-IMM and BRANCH into an `alu_pkg::alu_op` operator.
- Reads operands from an internal 31×32 register file, tracks pending writebacks with a scoreboard, and presents a registered `{operator, op_a, op_b, rd}` bundle to the ALU.
- Writeback results return through a dedicated write port.

## Interface
Parameters:
- None. Widths are fixed by RV32I.

Ports:
- `clk_i`  in  1  clock, single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `instr_valid_i`  in  1  instruction offered.
- `instr_i`  in  32  RV32I instruction word.
- `instr_ready_o`  out  1  instruction accepted this cycle when high with `instr_valid_i`.
- `alu_valid_o`  out  1  bundle valid.
- `alu_ready_i`  in  1  ALU consumes bundle.
- `alu_operator_o`  out  `alu_op`  ALU operation.
- `alu_op_a_o`  out  32  operand a.
- `alu_op_b_o`  out  32  operand b.
- `alu_rd_o`  out  5  destination register; 0 for branches.
- `alu_is_branch_o`  out  1  bundle is a compare for a branch.
- `wb_en_i`  in  1  writeback strobe.
- `wb_addr_i`  in  5  writeback register.
- `wb_data_i`  in  32  writeback data.
- `illegal_o`  out  1  one-cycle pulse on an accepted unsupported instruction.

## Operation
Decode:
- OP (0110011): operator from funct3/funct7.
  - funct7 0000000 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000 with funct3 000 maps to SUB; with funct3 101 maps to SRA.
  - Any other funct7 is illegal.
  - `op_a`=rs1, `op_b`=rs2.
- OP-IMM (0010011): same funct3 mapping, with these rules:
  - There is no SUB.
  - `op_b` = sign-extended imm[11:0].
  - For shifts, `op_b` = {27'b0, shamt}.
  - SLLI needs imm[11:5]=0. SRLI/SRAI need imm[11:5]=0000000/0100000 respectively. Anything else is illegal.
- BRANCH (1100011): funct3 maps 000→EQ, 001→NE, 100→LT, 101→GE, 110→LTU, 111→GEU; 010/011 are illegal.
  - `op_a`=rs1, `op_b`=rs2.
  - `rd_o`=0, `is_branch_o`=1.
- Any other opcode is illegal.
- Illegal instructions:
  - Accepted (handshake completes) and dropped.
  - Produce no bundle and no scoreboard change.
  - `illegal_o` pulses high the cycle after acceptance.

Register file (`alu_regfile`):
- x0 reads 0.
- Writes on `wb_en_i` with `wb_addr_i`≠0 take effect at the clock edge.
- Reads are combinational.

Scoreboard:
- 32 busy bits; bit 0 is always 0.
- Set for rd≠0 on acceptance of a legal non-branch instruction.
- Cleared on `wb_en_i` for that address.
- When set and clear hit the same register in one cycle, set wins.

Stall:
- `instr_ready_o` = ~hazard & (~`alu_valid_o` | `alu_ready_i`).
- hazard = busy[rs1] | (uses rs2 & busy[rs2]) | busy[rd].
- Stall is evaluated only for legal decodes; illegal instructions never stall on hazards.

## Timing
- Latency is 1: an instruction accepted at edge N is presented on the `alu_*` outputs from edge N onward.
- Bundle is held stable while `alu_valid_o` & ~`alu_ready_i`.
- `alu_valid_o` drops after the consuming edge unless a new instruction is accepted on that same edge (back-to-back throughput of 1/cycle).
- Readiness and `instr_valid_i` handshake: ready is not conditioned on valid; ready may depend combinationally on `instr_i` through the hazard check.
- Writeback without forwarding: a register cleared by `wb_en_i` in cycle C becomes readable (no hazard, new data) in cycle C+1.
- Reset values:
  - `alu_valid_o`=0, `illegal_o`=0.
  - All bundle outputs are 0; operator is ADD.
  - Scoreboard and register file are all zero.
- Reset mid-operation discards the pending bundle and any outstanding writebacks.
- `instr_ready_o` is 0 during the reset cycle.

## Configuration
Macro `ALU_DECODE_FORWARD_EN`:
- Defined:
  - A same-cycle `wb_en_i` matching rs1/rs2/rd clears that hazard.
  - The matching operand takes `wb_data_i` instead of the register file value.
  - Writeback-to-issue bubble is 0 cycles.
- Undefined:
  - No bypass; a dependent instruction waits one cycle after writeback (see Timing).

## Structure
- `alu_pkg` additions:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_BRANCH.
  - A decoded-bundle struct `{alu_op operator; logic [31:0] op_a, op_b; logic [4:0] rd; logic is_branch}`.
- Sub-module `alu_regfile`: 31×32 storage, two combinational read ports, one write port, synchronous reset.
- Decoder, scoreboard and output register live in `alu_decode_stage`.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093), `alu_ready_i`=1 → next cycle `alu_valid_o`=1, ADD, a=0, b=5, rd=1; busy[1]=1.
- Continue from above: ADD x2,x1,x1 (0x00108133) → `instr_ready_o`=0 until `wb_en_i` addr 1 data 5.
  - Without macro: accepted the cycle after, a=b=5, SUB not asserted.
  - With macro: accepted in the writeback cycle itself.
- With x1=5, x3 busy-free: SRAI x3,x1,4 (0x4040D193) → SRA, a=5, b=4, rd=3.
- BEQ x1,x2,0 (0x00208063) → EQ, rd=0, `is_branch_o`=1, scoreboard unchanged.
- JAL (0x0000006F) → accepted, `illegal_o` high exactly one cycle, `alu_valid_o` stays 0.
- Hold `alu_ready_i`=0 with a valid bundle, offer a new instruction → `instr_ready_o`=0, bundle unchanged; raise `alu_ready_i` → new bundle next cycle with no bubble.
